// File: rtl/qpu_mcu_measure_collect_if.sv
// Bus bundle for the measurement collector: issue handshake, discriminator
// strobes, regfile write-back and status.
interface qpu_mcu_measure_collect_if #(
   parameter int QUBIT_NUM  = 12,
   parameter int FIFO_DEPTH = 4
);
   localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;

   logic                 meas_issue_valid;
   logic                 meas_issue_ready;
   logic [QUBIT_NUM-1:0] meas_issue_list;
   logic [QUBIT_NUM-1:0] ro_result_valid;
   logic [QUBIT_NUM-1:0] ro_result_data;
   logic                 mcu_measure_o_wen;
   logic [QUBIT_NUM-1:0] mcu_measure_o_data;
   logic [QUBIT_NUM-1:0] mcu_measure_o_list;
   logic                 timeout_err;
   logic                 stray_err;
   logic [CNT_W-1:0]     pending_cnt;

   modport master (
      output meas_issue_valid,
      output meas_issue_list,
      output ro_result_valid,
      output ro_result_data,
      input  meas_issue_ready,
      input  mcu_measure_o_wen,
      input  mcu_measure_o_data,
      input  mcu_measure_o_list,
      input  timeout_err,
      input  stray_err,
      input  pending_cnt
   );

   modport slave (
      input  meas_issue_valid,
      input  meas_issue_list,
      input  ro_result_valid,
      input  ro_result_data,
      output meas_issue_ready,
      output mcu_measure_o_wen,
      output mcu_measure_o_data,
      output mcu_measure_o_list,
      output timeout_err,
      output stray_err,
      output pending_cnt
   );
endinterface

// File: rtl/qpu_mcu_measure_collect.sv
// Collects per-qubit readout results for in-order measurement lists and
// retires each list to the regfile on completion or timeout.
module qpu_mcu_measure_collect #(
   parameter int QUBIT_NUM   = 12,
   parameter int FIFO_DEPTH  = 4,
   parameter int TIMEOUT_CYC = 1023
) (
   input  logic                    clk,
   input  logic                    rst,
   qpu_mcu_measure_collect_if.slave bus
);
   localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
   localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;

   localparam logic [0:0] IDLE    = 1'b0;
   localparam logic [0:0] COLLECT = 1'b1;

   localparam logic [CNT_W-1:0] DEPTH_CNT    = CNT_W'(FIFO_DEPTH);
   localparam logic [PTR_W-1:0] LAST_PTR     = PTR_W'(FIFO_DEPTH - 1);
   localparam logic [15:0]      TIMEOUT_LAST = 16'(TIMEOUT_CYC - 1);

   logic [QUBIT_NUM-1:0] fifo_mem [FIFO_DEPTH];
   logic [PTR_W-1:0]     wr_ptr;
   logic [PTR_W-1:0]     rd_ptr;
   logic [PTR_W-1:0]     wr_ptr_next;
   logic [PTR_W-1:0]     rd_ptr_next;
   logic [CNT_W-1:0]     count;
   logic [CNT_W-1:0]     count_next;
   logic [0:0]           state;
   logic                 ready_en;

   logic [QUBIT_NUM-1:0] got;
   logic [QUBIT_NUM-1:0] data;
   logic [15:0]          age;

   logic [QUBIT_NUM-1:0] head_list;
   logic [QUBIT_NUM-1:0] capture;
   logic [QUBIT_NUM-1:0] stray_mask;
   logic [QUBIT_NUM-1:0] got_next;
   logic [QUBIT_NUM-1:0] data_next;
   logic                 collecting;
   logic                 push;
   logic                 complete;
   logic                 expired;
   logic                 pop;

   logic                 wen_q;
   logic                 timeout_q;
   logic                 stray_q;
   logic [QUBIT_NUM-1:0] out_data_q;
   logic [QUBIT_NUM-1:0] out_list_q;

   // Ready comes from registered occupancy only; ready_en keeps it low during
   // reset and for the first cycle afterwards.
   assign bus.meas_issue_ready   = ready_en && (count < DEPTH_CNT);
   assign bus.pending_cnt        = count;
   assign bus.mcu_measure_o_wen  = wen_q;
   assign bus.mcu_measure_o_data = out_data_q;
   assign bus.mcu_measure_o_list = out_list_q;
   assign bus.timeout_err        = timeout_q;
   assign bus.stray_err          = stray_q;

   // A strobe is consumed only when it belongs to the head list and has not
   // been seen yet; everything else is stray. Completion includes this cycle's captures.
   always_comb begin
      head_list   = fifo_mem[rd_ptr];
      collecting  = (state == COLLECT);
      push        = bus.meas_issue_valid && bus.meas_issue_ready && (|bus.meas_issue_list);
      capture     = collecting ? (bus.ro_result_valid & head_list & ~got) : '0;
      stray_mask  = bus.ro_result_valid & ~capture;
      got_next    = got | capture;
      data_next   = data | (bus.ro_result_data & capture);
      complete    = collecting && (got_next == head_list);
      expired     = collecting && !complete && (age == TIMEOUT_LAST);
      pop         = complete || expired;
      wr_ptr_next = (wr_ptr == LAST_PTR) ? '0 : wr_ptr + 1'b1;
      rd_ptr_next = (rd_ptr == LAST_PTR) ? '0 : rd_ptr + 1'b1;
      count_next  = count + {{(CNT_W-1){1'b0}}, push} - {{(CNT_W-1){1'b0}}, pop};
   end

   // List storage needs no reset: occupancy and pointers define validity.
   always_ff @(posedge clk) begin
      if (!rst && push) begin
         fifo_mem[wr_ptr] <= bus.meas_issue_list;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr   <= '0;
         rd_ptr   <= '0;
         count    <= '0;
         state    <= IDLE;
         ready_en <= 1'b0;
      end else begin
         ready_en <= 1'b1;
         count    <= count_next;
         state    <= (count_next != '0) ? COLLECT : IDLE;
         if (push) begin
            wr_ptr <= wr_ptr_next;
         end
         if (pop) begin
            rd_ptr <= rd_ptr_next;
         end
      end
   end

   // Each head gets exactly TIMEOUT_CYC collect cycles; retiring clears the
   // per-list state so the next head starts clean on the following cycle.
   always_ff @(posedge clk) begin
      if (rst) begin
         got  <= '0;
         data <= '0;
         age  <= '0;
      end else if (!collecting || pop) begin
         got  <= '0;
         data <= '0;
         age  <= '0;
      end else begin
         got  <= got_next;
         data <= data_next;
         age  <= age + 16'd1;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         wen_q      <= 1'b0;
         timeout_q  <= 1'b0;
         stray_q    <= 1'b0;
         out_data_q <= '0;
         out_list_q <= '0;
      end else begin
         wen_q     <= pop;
         timeout_q <= expired;
         stray_q   <= |stray_mask;
         if (pop) begin
            out_data_q <= data_next;
            out_list_q <= head_list;
         end
      end
   end
endmodule

// File: tb/tb_qpu_mcu_measure_collect.sv
// Scoreboard bench: a list-level reference model predicts retirements and
// stray pulses; a negedge monitor matches them against the DUT outputs.
module tb_qpu_mcu_measure_collect;
   localparam int QN    = 12;
   localparam int DEPTH = 4;
   localparam int TMO   = 24;
   localparam int CNT_W = $clog2(DEPTH) + 1;

   typedef struct {
      int          cyc;
      logic [QN-1:0] data;
      logic [QN-1:0] list;
      logic          tmo;
   } retire_t;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   qpu_mcu_measure_collect_if #(.QUBIT_NUM(QN), .FIFO_DEPTH(DEPTH)) bus ();

   qpu_mcu_measure_collect #(
      .QUBIT_NUM  (QN),
      .FIFO_DEPTH (DEPTH),
      .TIMEOUT_CYC(TMO)
   ) dut (
      .clk(clk),
      .rst(rst),
      .bus(bus)
   );

   retire_t       exp_q[$];
   int            stray_q[$];
   logic [QN-1:0] model_q[$];
   logic [QN-1:0] m_got;
   logic [QN-1:0] m_data;
   int            m_age;
   bit            m_ready_en;
   int            cycle;
   int            checks;
   int            errors;

   // Reference model: one call per clock edge with the inputs the DUT sampled.
   task automatic modelStep();
      logic [QN-1:0] head;
      logic [QN-1:0] fresh;
      logic [QN-1:0] stray;
      bit            accepted;
      retire_t       r;
      if (rst) begin
         model_q.delete();
         m_got      = '0;
         m_data     = '0;
         m_age      = 0;
         m_ready_en = 1'b0;
         return;
      end
      accepted = bus.meas_issue_valid && m_ready_en && (model_q.size() < DEPTH);
      stray    = bus.ro_result_valid;
      if (model_q.size() > 0) begin
         head   = model_q[0];
         fresh  = bus.ro_result_valid & head & ~m_got;
         stray  = bus.ro_result_valid & ~fresh;
         m_got  = m_got | fresh;
         m_data = m_data | (bus.ro_result_data & fresh);
         m_age++;
         if (m_got == head || m_age == TMO) begin
            r.cyc  = cycle;
            r.data = m_data;
            r.list = head;
            r.tmo  = (m_got != head);
            exp_q.push_back(r);
            void'(model_q.pop_front());
            m_got  = '0;
            m_data = '0;
            m_age  = 0;
         end
      end
      if (stray != '0) stray_q.push_back(cycle);
      if (accepted && bus.meas_issue_list != '0) model_q.push_back(bus.meas_issue_list);
      m_ready_en = 1'b1;
   endtask

   task automatic checkOutput();
      logic          exp_ready;
      logic [CNT_W-1:0] exp_cnt;
      exp_ready = m_ready_en && (model_q.size() < DEPTH);
      exp_cnt   = CNT_W'(model_q.size());
      checks++;
      if (bus.meas_issue_ready !== exp_ready) begin
         errors++;
         $display("[TB] FAIL ready cycle %0d: got %b expected %b", cycle, bus.meas_issue_ready, exp_ready);
      end
      checks++;
      if (bus.pending_cnt !== exp_cnt) begin
         errors++;
         $display("[TB] FAIL pending_cnt cycle %0d: got %0d expected %0d", cycle, bus.pending_cnt, exp_cnt);
      end
   endtask

   task automatic applyStimulus(input logic r, input logic v, input logic [QN-1:0] list,
                                input logic [QN-1:0] rv, input logic [QN-1:0] rd);
      rst                  = r;
      bus.meas_issue_valid = v;
      bus.meas_issue_list  = list;
      bus.ro_result_valid  = rv;
      bus.ro_result_data   = rd;
      @(posedge clk);
      cycle++;
      modelStep();
      #1;
      checkOutput();
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) applyStimulus(1'b0, 1'b0, '0, '0, '0);
   endtask

   task automatic doReset();
      applyStimulus(1'b1, 1'b0, '0, '0, '0);
      applyStimulus(1'b1, 1'b0, '0, '0, '0);
      idle(1);
   endtask

   // Monitor: matches every wen / stray pulse against the predicted cycle.
   always @(negedge clk) begin
      retire_t e;
      if (cycle > 0) begin
         while (exp_q.size() > 0 && exp_q[0].cyc < cycle) begin
            checks++; errors++;
            $display("[TB] FAIL missed_wen: got none expected list %h at cycle %0d", exp_q[0].list, exp_q[0].cyc);
            void'(exp_q.pop_front());
         end
         while (stray_q.size() > 0 && stray_q[0] < cycle) begin
            checks++; errors++;
            $display("[TB] FAIL missed_stray: got none expected pulse at cycle %0d", stray_q[0]);
            void'(stray_q.pop_front());
         end
         if (bus.mcu_measure_o_wen !== 1'b0) begin
            checks++;
            if (exp_q.size() == 0 || exp_q[0].cyc != cycle) begin
               errors++;
               $display("[TB] FAIL unexpected_wen cycle %0d: got wen=%b list %h expected no write", cycle, bus.mcu_measure_o_wen, bus.mcu_measure_o_list);
            end else begin
               e = exp_q.pop_front();
               if (bus.mcu_measure_o_data !== e.data) begin
                  errors++;
                  $display("[TB] FAIL wen_data cycle %0d: got %h expected %h", cycle, bus.mcu_measure_o_data, e.data);
               end
               checks++;
               if (bus.mcu_measure_o_list !== e.list) begin
                  errors++;
                  $display("[TB] FAIL wen_list cycle %0d: got %h expected %h", cycle, bus.mcu_measure_o_list, e.list);
               end
               checks++;
               if (bus.timeout_err !== e.tmo) begin
                  errors++;
                  $display("[TB] FAIL timeout_err cycle %0d: got %b expected %b", cycle, bus.timeout_err, e.tmo);
               end
            end
         end else if (bus.timeout_err !== 1'b0) begin
            checks++; errors++;
            $display("[TB] FAIL timeout_err_alone cycle %0d: got %b expected 0", cycle, bus.timeout_err);
         end
         if (bus.stray_err !== 1'b0) begin
            checks++;
            if (stray_q.size() > 0 && stray_q[0] == cycle) begin
               void'(stray_q.pop_front());
            end else begin
               errors++;
               $display("[TB] FAIL unexpected_stray cycle %0d: got %b expected 0", cycle, bus.stray_err);
            end
         end
      end
   end

   function automatic logic [QN-1:0] pickStrobes();
      logic [QN-1:0] m;
      if (model_q.size() > 0 && $urandom_range(0, 2) == 0) m = model_q[0] & QN'($urandom);
      else if ($urandom_range(0, 3) == 0) m = QN'($urandom & $urandom & $urandom);
      else m = '0;
      return m;
   endfunction

   initial begin
      logic [QN-1:0] rl;
      cycle = 0; checks = 0; errors = 0;
      m_got = '0; m_data = '0; m_age = 0; m_ready_en = 1'b0;
      bus.meas_issue_valid = 1'b0;
      bus.meas_issue_list  = '0;
      bus.ro_result_valid  = '0;
      bus.ro_result_data   = '0;
      doReset();

      // Single list, two strobes, second one reads 0.
      applyStimulus(1'b0, 1'b1, 12'h005, '0, '0);
      idle(1);
      applyStimulus(1'b0, 1'b0, '0, 12'h001, 12'h001);
      idle(1);
      applyStimulus(1'b0, 1'b0, '0, 12'h004, 12'h000);
      idle(3);

      // Fill FIFO, fifth offer held until the head retires.
      applyStimulus(1'b0, 1'b1, 12'h001, '0, '0);
      applyStimulus(1'b0, 1'b1, 12'h002, '0, '0);
      applyStimulus(1'b0, 1'b1, 12'h004, '0, '0);
      applyStimulus(1'b0, 1'b1, 12'h008, '0, '0);
      applyStimulus(1'b0, 1'b1, 12'h010, '0, '0);
      applyStimulus(1'b0, 1'b1, 12'h010, 12'h001, 12'h001);
      applyStimulus(1'b0, 1'b1, 12'h010, '0, '0);
      applyStimulus(1'b0, 1'b0, '0, 12'h002, 12'h002);
      applyStimulus(1'b0, 1'b0, '0, 12'h004, 12'h000);
      applyStimulus(1'b0, 1'b0, '0, 12'h008, 12'h008);
      applyStimulus(1'b0, 1'b0, '0, 12'h010, 12'h010);
      idle(3);

      // Timeout with one missing bit, plus stray and repeated strobes.
      applyStimulus(1'b0, 1'b1, 12'h003, '0, '0);
      applyStimulus(1'b0, 1'b0, '0, 12'h020, 12'h020);
      applyStimulus(1'b0, 1'b0, '0, 12'h001, 12'h001);
      applyStimulus(1'b0, 1'b0, '0, 12'h001, 12'h000);
      idle(TMO + 3);

      // All-zero list is swallowed; simultaneous strobes across two lists.
      applyStimulus(1'b0, 1'b1, 12'h000, '0, '0);
      applyStimulus(1'b0, 1'b1, 12'h001, '0, '0);
      applyStimulus(1'b0, 1'b1, 12'h002, '0, '0);
      applyStimulus(1'b0, 1'b0, '0, 12'h003, 12'h003);
      applyStimulus(1'b0, 1'b0, '0, 12'h002, 12'h002);
      idle(3);

      // Reset with partial results outstanding, then a fresh list.
      applyStimulus(1'b0, 1'b1, 12'h00F, '0, '0);
      applyStimulus(1'b0, 1'b1, 12'h030, '0, '0);
      applyStimulus(1'b0, 1'b0, '0, 12'h001, 12'h001);
      applyStimulus(1'b1, 1'b0, '0, 12'h006, 12'h006);
      applyStimulus(1'b1, 1'b0, '0, '0, '0);
      idle(1);
      applyStimulus(1'b0, 1'b1, 12'h001, '0, '0);
      applyStimulus(1'b0, 1'b0, '0, 12'h001, 12'h001);
      idle(3);

      // Randomised traffic with occasional resets.
      for (int i = 0; i < 1500; i++) begin
         rl = ($urandom_range(0, 7) == 0) ? '0 : QN'($urandom & $urandom);
         applyStimulus(($urandom_range(0, 299) == 0), ($urandom_range(0, 2) == 0), rl,
                       pickStrobes(), QN'($urandom));
      end
      idle(DEPTH * TMO + 10);

      checks++;
      if (exp_q.size() != 0 || stray_q.size() != 0) begin
         errors++;
         $display("[TB] FAIL drain: got %0d writes and %0d strays outstanding expected 0", exp_q.size(), stray_q.size());
      end
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule

// File: doc/qpu_mcu_measure_collect.md
QPU_MCU_MEASURE_COLLECT -- requirements
Module: qpu_mcu_measure_collect

Interface
REQ-001 SHALL have parameter QUBIT_NUM, default 12, number of physical qubits.
REQ-002 SHALL have parameter FIFO_DEPTH, default 4 (power of two), number of outstanding measurement lists.
REQ-003 SHALL have parameter TIMEOUT_CYC, default 1023, maximum collect cycles per list (16-bit counter).
REQ-004 SHALL provide clk  input  1  single clock; all logic on rising edge.
REQ-005 SHALL provide rst  input  1  reset, synchronous and active-high.
REQ-006 SHALL provide meas_issue_valid  input  1  measurement list offered by event queue.
REQ-007 SHALL provide meas_issue_ready  output  1  list accepted when valid and ready are both high.
REQ-008 SHALL provide meas_issue_list  input  QUBIT_NUM  one-hot-per-qubit mask of measured qubits.
REQ-009 SHALL provide ro_result_valid  input  QUBIT_NUM  per-qubit readout strobe from discriminator.
REQ-010 SHALL provide ro_result_data  input  QUBIT_NUM  per-qubit discriminated state; bit k valid when ro_result_valid[k].
REQ-011 SHALL provide mcu_measure_o_wen  output  1  one-cycle write pulse to regfile measurement registers.
REQ-012 SHALL provide mcu_measure_o_data  output  QUBIT_NUM  collected results, valid with wen.
REQ-013 SHALL provide mcu_measure_o_list  output  QUBIT_NUM  qubit list being retired, valid with wen (OITF return list).
REQ-014 SHALL provide timeout_err  output  1  one-cycle pulse when a list retires by timeout.
REQ-015 SHALL provide stray_err  output  1  one-cycle pulse when any result strobe is discarded.
REQ-016 SHALL provide pending_cnt  output  $clog2(FIFO_DEPTH)+1  number of lists in FIFO, including head.

Function
REQ-017 SHALL hold issued lists in an in-order FIFO; meas_issue_ready = (pending_cnt < FIFO_DEPTH), from registered count only (no same-cycle pop bypass).
REQ-018 SHALL discard an accepted all-zero list (handshake completes, FIFO unchanged).
REQ-019 SHALL implement states IDLE (FIFO empty) and COLLECT (head list present); IDLE->COLLECT the cycle after a push into an empty FIFO.
REQ-020 In COLLECT, for each k with ro_result_valid[k] & head_list[k] & ~got[k], SHALL capture ro_result_data[k] into the data register and set got[k].
REQ-021 SHALL discard strobes for qubits not in head_list, already in got, or arriving in IDLE, and pulse stray_err next cycle.
REQ-022 SHALL detect completion when (got | newly captured) == head_list, including the same-cycle case.
REQ-023 On completion at cycle N, SHALL assert mcu_measure_o_wen at N+1 with data/list registered; missing bits SHALL be 0.
REQ-024 On completion SHALL pop the head, clear got and data, and reset the timeout counter; next entry accepts results from N+1 (COLLECT) or state goes IDLE if FIFO empty.
REQ-025 SHALL count COLLECT cycles per head entry; when count reaches TIMEOUT_CYC without completion, SHALL retire as in REQ-023/024 and pulse timeout_err together with mcu_measure_o_wen.
REQ-026 SHALL allow push and pop in the same cycle; pending_cnt unchanged.
REQ-027 SHALL keep mcu_measure_o_wen, timeout_err, stray_err low in all cycles other than those defined above.
REQ-028 FIFO pointers SHALL wrap modulo FIFO_DEPTH.

Reset
REQ-029 While rst is high at a clock edge, SHALL clear FIFO, got, data, counter, state to IDLE, all outputs to 0, meas_issue_ready to 0; ready rises the cycle after rst deasserts.
REQ-030 Reset mid-collection SHALL drop all pending lists with no wen pulse.

Verification
REQ-031 Push list 0x005; strobe q0=1 at cycle 3, q2=0 at cycle 5 -> wen at cycle 6, data 0x001, list 0x005, pending_cnt 1->0.
REQ-032 Push 4 lists back-to-back -> ready low with pending_cnt=4; complete head -> ready high next cycle, fifth push accepted.
REQ-033 Push 0x003, strobe only q0 -> after TIMEOUT_CYC cycles wen with data bit1=0, list 0x003, timeout_err same cycle.
REQ-034 Strobe q5 while head list 0x003, and repeated q0 strobe -> stray_err pulses, data unaffected.
REQ-035 Lists 0x001, 0x002 queued; q0 and q1 strobed simultaneously -> wen for 0x001 only, q1 counted stray; q1 re-strobed -> second wen, list 0x002.
REQ-036 Assert rst with 2 lists pending and partial results -> no wen, pending_cnt 0, new push then behaves as fresh.
